// File: rtl/tbuf_arb_pkg.sv
// Shared types and helpers for the tri-state bus arbiter.
package tbuf_arb_pkg;

  localparam int DEAD_MAX = 15;
  localparam int N_MAX    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  // One-hot decode of a driver index, sized for the largest legal bank.
  function automatic logic [N_MAX-1:0] onehot_of(input logic [3:0] idx);
    logic [N_MAX-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/tbuf_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping, found by priority-encoding a doubled request vector whose bits
// below ptr are masked off.
module tbuf_rr_pick
  import tbuf_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] req2;
  logic [2*N-1:0] mask2;
  logic [2*N-1:0] cand;

  assign req2  = {req, req};
  assign mask2 = ~(((2*N)'(1) << ptr) - (2*N)'(1));
  assign cand  = req2 & mask2;

  // Lowest surviving candidate wins; the upper copy supplies the wrap-around.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int j = 2*N-1; j >= 0; j--) begin
      if (cand[j]) idx = IW'(j % N);
    end
  end

endmodule

// File: rtl/tbuf_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus built from 12T tbuf drivers.
// EN/EN_BAR come straight from flops, tenure is bounded when others wait,
// and DEAD all-off cycles separate every change of owner.
module tbuf_bus_arbiter
  import tbuf_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int DEAD     = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N-1:0]         REQ,
  output logic [N-1:0]         EN,
  output logic [N-1:0]         EN_BAR,
  output logic [N-1:0]         GNT,
  output logic [$clog2(N)-1:0] OWNER,
  output logic                 BUS_IDLE
);

  localparam int IW = $clog2(N);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

  arb_state_e       state_q;
  logic [N-1:0]     en_q;
  logic [N-1:0]     enb_q;
  logic [IW-1:0]    owner_q;
  logic [IW-1:0]    ptr_q;
  logic [HW-1:0]    hold_q;
  logic [3:0]       dead_q;

  logic             pick_vld;
  logic [IW-1:0]    pick_idx;
  logic [N_MAX-1:0] pick_oh_full;
  logic [N_MAX-1:0] own_oh_full;
  logic [N-1:0]     pick_oh;
  logic [N-1:0]     own_oh;
  logic [IW-1:0]    next_ptr;
  logic             rel;

  tbuf_rr_pick #(.N(N)) u_pick (
    .req   (REQ),
    .ptr   (ptr_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign pick_oh_full = onehot_of(4'(pick_idx));
  assign own_oh_full  = onehot_of(4'(owner_q));
  assign pick_oh      = pick_oh_full[N-1:0];
  assign own_oh       = own_oh_full[N-1:0];

  if (N < N_MAX) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^{pick_oh_full[N_MAX-1:N], own_oh_full[N_MAX-1:N]};
  end

  assign next_ptr = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;

  // Release on owner drop, or on tenure expiry while someone else waits.
  assign rel = !REQ[owner_q] ||
               ((MAX_HOLD != 0) && (hold_q == HOLD_LAST) && ((REQ & ~own_oh) != '0));

  // Arbitration FSM with tenure/dead counters and the registered tbuf enables.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      en_q    <= '0;
      enb_q   <= '1;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      dead_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            en_q    <= pick_oh;
            enb_q   <= ~pick_oh;
            owner_q <= pick_idx;
            hold_q  <= '0;
            state_q <= DRIVE;
          end
        end
        DRIVE: begin
          if (rel) begin
            en_q    <= '0;
            enb_q   <= '1;
            ptr_q   <= next_ptr;
            dead_q  <= 4'(DEAD - 1);
            state_q <= TURN;
          end else if (hold_q != HOLD_LAST) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        TURN: begin
          if (dead_q != 4'd0) begin
            dead_q <= dead_q - 4'd1;
          end else if (pick_vld) begin
            en_q    <= pick_oh;
            enb_q   <= ~pick_oh;
            owner_q <= pick_idx;
            hold_q  <= '0;
            state_q <= DRIVE;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign EN       = en_q;
  assign EN_BAR   = enb_q;
  assign GNT      = en_q;
  assign OWNER    = owner_q;
  assign BUS_IDLE = ~|en_q;

  a_onehot0: assert property (@(posedge CLK) disable iff (RST) $onehot0(EN));
  a_compl:   assert property (@(posedge CLK) disable iff (RST) EN_BAR == ~EN);
  a_bbm:     assert property (@(posedge CLK) disable iff (RST)
                              ($past(EN) != '0 && EN != '0) |-> EN == $past(EN));

endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// Scoreboarded bench: four arbiters with different DEAD/MAX_HOLD share one
// stimulus stream; a bus-ownership model predicts every cycle's outputs.
module tb_tbuf_bus_arbiter;

  localparam int ND = 4;

  function automatic int dead_of(input int d);
    case (d)
      0: return 1;
      1: return 3;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int mh_of(input int d);
    case (d)
      0: return 16;
      1: return 4;
      2: return 2;
      default: return 0;
    endcase
  endfunction

  typedef struct packed {
    logic [ND-1:0][3:0] en;
    logic [ND-1:0][1:0] own;
    logic [ND-1:0]      idle;
  } exp_t;

  exp_t sb[$];

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] REQ;

  logic [3:0] en_w   [ND];
  logic [3:0] enb_w  [ND];
  logic [3:0] gnt_w  [ND];
  logic [1:0] own_w  [ND];
  logic       idle_w [ND];

  int checks = 0;
  int errors = 0;

  // Reference model: who drives, who drove last, rr start, tenure so far,
  // and how many more all-off edges must pass before arbitration.
  int m_drv  [ND];
  int m_last [ND];
  int m_ptr  [ND];
  int m_ten  [ND];
  int m_wait [ND];

  bit rec_b = 0;
  bit rec_c = 0;
  int gq_b[$];
  int gq_c[$];
  logic [3:0] prev_en [ND];

  always #5 CLK = ~CLK;

  tbuf_bus_arbiter #(.N(4), .DEAD(1), .MAX_HOLD(16)) u0 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .EN(en_w[0]), .EN_BAR(enb_w[0]),
    .GNT(gnt_w[0]), .OWNER(own_w[0]), .BUS_IDLE(idle_w[0]));
  tbuf_bus_arbiter #(.N(4), .DEAD(3), .MAX_HOLD(4)) u1 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .EN(en_w[1]), .EN_BAR(enb_w[1]),
    .GNT(gnt_w[1]), .OWNER(own_w[1]), .BUS_IDLE(idle_w[1]));
  tbuf_bus_arbiter #(.N(4), .DEAD(2), .MAX_HOLD(2)) u2 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .EN(en_w[2]), .EN_BAR(enb_w[2]),
    .GNT(gnt_w[2]), .OWNER(own_w[2]), .BUS_IDLE(idle_w[2]));
  tbuf_bus_arbiter #(.N(4), .DEAD(1), .MAX_HOLD(0)) u3 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .EN(en_w[3]), .EN_BAR(enb_w[3]),
    .GNT(gnt_w[3]), .OWNER(own_w[3]), .BUS_IDLE(idle_w[3]));

  task automatic chk(input string nm, input int d, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %0h expected %0h", nm, d, $time, got, want);
    end
  endtask

  task automatic model_step(input int d, input logic [3:0] r, input logic rs);
    int pick;
    logic [3:0] others;
    if (rs) begin
      m_drv[d] = -1; m_last[d] = 0; m_ptr[d] = 0; m_ten[d] = 0; m_wait[d] = 0;
    end else if (m_drv[d] >= 0) begin
      others = r & ~(4'b0001 << m_drv[d]);
      if (!r[m_drv[d]] || (mh_of(d) != 0 && m_ten[d] >= mh_of(d) && others != 4'b0)) begin
        m_ptr[d]  = (m_drv[d] + 1) % 4;
        m_drv[d]  = -1;
        m_wait[d] = dead_of(d) - 1;
      end else begin
        m_ten[d]++;
      end
    end else if (m_wait[d] > 0) begin
      m_wait[d]--;
    end else begin
      pick = -1;
      for (int k = 0; k < 4; k++) begin
        if (pick < 0 && r[(m_ptr[d] + k) % 4]) pick = (m_ptr[d] + k) % 4;
      end
      if (pick >= 0) begin
        m_drv[d] = pick; m_last[d] = pick; m_ten[d] = 1;
      end
    end
  endtask

  // Drive one cycle of stimulus and queue what every DUT must show after the edge.
  task automatic cyc(input logic [3:0] r, input logic rs);
    exp_t e;
    REQ = r;
    RST = rs;
    for (int d = 0; d < ND; d++) begin
      model_step(d, r, rs);
      e.en[d]   = (m_drv[d] < 0) ? 4'b0 : 4'(1 << m_drv[d]);
      e.own[d]  = 2'(m_last[d]);
      e.idle[d] = (m_drv[d] < 0);
    end
    sb.push_back(e);
    @(negedge CLK);
  endtask

  function automatic int idx_of(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Monitor: pop the prediction for this edge and compare all outputs.
  initial begin
    exp_t e;
    logic [3:0] inv_en;
    logic [3:0] want_bar;
    for (int d = 0; d < ND; d++) prev_en[d] = 4'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty t=%0t got empty queue expected an entry", $time);
      end else begin
        e = sb.pop_front();
        for (int d = 0; d < ND; d++) begin
          want_bar = ~e.en[d];
          inv_en   = ~en_w[d];
          chk("en",       d, 32'(en_w[d]),   32'(e.en[d]));
          chk("en_bar",   d, 32'(enb_w[d]),  32'(want_bar));
          chk("gnt",      d, 32'(gnt_w[d]),  32'(e.en[d]));
          chk("owner",    d, 32'(own_w[d]),  32'(e.own[d]));
          chk("bus_idle", d, 32'(idle_w[d]), 32'(e.idle[d]));
          chk("onehot0",  d, 32'($onehot0(en_w[d])), 32'(1));
          chk("compl",    d, 32'(enb_w[d]),  32'(inv_en));
          if (prev_en[d] != 4'b0 && en_w[d] != 4'b0)
            chk("bbm", d, 32'(en_w[d]), 32'(prev_en[d]));
          if (prev_en[d] == 4'b0 && en_w[d] != 4'b0) begin
            if (d == 1 && rec_b) gq_b.push_back(idx_of(en_w[d]));
            if (d == 2 && rec_c) gq_c.push_back(idx_of(en_w[d]));
          end
          prev_en[d] = en_w[d];
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic       rs;
    int         exp_b[4] = '{0, 1, 0, 1};
    int         exp_c[5] = '{0, 1, 2, 3, 0};

    cyc(4'b1111, 1'b1);
    cyc(4'b1111, 1'b1);
    rec_c = 1;
    repeat (24) cyc(4'b1111, 1'b0);
    rec_c = 0;
    repeat (5)  cyc(4'b0000, 1'b0);
    repeat (6)  cyc(4'b0100, 1'b0);
    repeat (4)  cyc(4'b0000, 1'b0);
    repeat (3)  cyc(4'b0001, 1'b0);
    repeat (2)  cyc(4'b0101, 1'b0);
    repeat (8)  cyc(4'b0100, 1'b0);
    repeat (3)  cyc(4'b0000, 1'b0);
    rec_b = 1;
    repeat (40) cyc(4'b0011, 1'b0);
    rec_b = 0;
    repeat (30) cyc(4'b0001, 1'b0);
    repeat (6)  cyc(4'b1000, 1'b0);
    cyc(4'b1000, 1'b1);
    repeat (3)  cyc(4'b1111, 1'b0);
    repeat (4)  cyc(4'b1000, 1'b0);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b1);
    repeat (4)  cyc(4'b0010, 1'b0);
    repeat (3)  cyc(4'b0000, 1'b0);

    r = 4'b0;
    repeat (10000) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 399) == 0);
      cyc(r, rs);
    end
    repeat (3) cyc(4'b0000, 1'b0);

    chk("sb_drain", 0, 32'(sb.size()), 32'(0));
    chk("b_grant_cnt", 1, 32'(gq_b.size() >= 4), 32'(1));
    for (int i = 0; i < 4; i++)
      if (i < gq_b.size()) chk("b_grant_order", 1, 32'(gq_b[i]), 32'(exp_b[i]));
    chk("c_grant_cnt", 2, 32'(gq_c.size() >= 5), 32'(1));
    for (int i = 0; i < 5; i++)
      if (i < gq_c.size()) chk("c_grant_order", 2, 32'(gq_c[i]), 32'(exp_c[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
